// File: rtl/spi_prot_trig.sv
// Passive SPI frame monitor: captures MOSI frames between SS_n edges and pulses
// SPItrig on a (masked) match or frm_err on a length error. Macro: SPI_TRIG_MASK_EN.
module spi_prot_trig #(
  parameter int MAX_W = 16,
  parameter int LEN_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  input  logic             pos_edge,
  input  logic [LEN_W-1:0] len,
  input  logic [MAX_W-1:0] match,
  input  logic [MAX_W-1:0] mask,
  output logic             SPItrig,
  output logic [MAX_W-1:0] rx_data,
  output logic             frm_err
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [LEN_W-1:0] CNT_SAT = LEN_W'(MAX_W + 1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_W);

  state_e           state_q, state_d;
  logic [2:0]       ss_sync_q, sclk_sync_q, valid_q;
  logic [1:0]       mosi_sync_q;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [MAX_W-1:0] shift_q, shift_d;
  logic [MAX_W-1:0] rx_q, rx_d;
  logic             trig_q, trig_d;
  logic             err_q, err_d;

  logic             ss_fall, ss_rise, sclk_edge, len_ok, hit;
  logic [MAX_W-1:0] lenmask, eff_mask;

  // valid_q marks when the synchroniser tail holds a real pin sample, so a low
  // SS_n at reset release is not mistaken for a fresh frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_sync_q   <= 3'b111;
      sclk_sync_q <= 3'b000;
      mosi_sync_q <= 2'b00;
      valid_q     <= 3'b000;
    end else begin
      ss_sync_q   <= {ss_sync_q[1:0], SS_n};
      sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      valid_q     <= {valid_q[1:0], 1'b1};
    end
  end

  assign ss_fall   = valid_q[2] & ss_sync_q[2] & ~ss_sync_q[1];
  assign ss_rise   = ~ss_sync_q[2] & ss_sync_q[1];
  assign sclk_edge = pos_edge ? (~sclk_sync_q[2] & sclk_sync_q[1])
                              : (sclk_sync_q[2] & ~sclk_sync_q[1]);

`ifdef SPI_TRIG_MASK_EN
  assign eff_mask = mask;
`else
  logic unused_mask;
  assign unused_mask = ^mask;
  assign eff_mask    = '1;
`endif

  assign len_ok  = (len != '0) && (len <= LEN_MAX);
  assign lenmask = ~({MAX_W{1'b1}} << len);
  assign hit     = (((shift_q ^ match) & eff_mask & lenmask) == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    rx_d    = rx_q;
    trig_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && ss_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (ss_rise) begin
          // Frame end wins over any SCLK edge seen in the same cycle.
          state_d = IDLE;
          rx_d    = shift_q;
          if (len_ok && (cnt_q == len)) trig_d = hit;
          else                          err_d  = 1'b1;
        end else if (sclk_edge) begin
          shift_d = {shift_q[MAX_W-2:0], mosi_sync_q[1]};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      rx_q    <= '0;
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      rx_q    <= rx_d;
      trig_q  <= trig_d;
      err_q   <= err_d;
    end
  end

  assign SPItrig = trig_q;
  assign frm_err = err_q;
  assign rx_data = rx_q;

endmodule

// File: doc/spi_prot_trig.md
SPI_PROT_TRIG -- requirements
Module: spi_prot_trig

Interface
REQ-001 SHALL have parameter MAX_W, default 16, meaning maximum frame length in bits (legal 8..32).
REQ-002 SHALL have parameter LEN_W, default 6, meaning width of len port and bit counter (must hold MAX_W+1).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge (one clock domain).
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  trigger enable; low forces IDLE and suppresses outputs.
REQ-006 SHALL have port SS_n, SCLK, MOSI  input  1 each  asynchronous monitored SPI pins.
REQ-007 SHALL have port pos_edge  input  1  1 = sample MOSI on SCLK rise, 0 = on SCLK fall.
REQ-008 SHALL have port len  input  LEN_W  expected frame length in bits.
REQ-009 SHALL have port match  input  MAX_W  compare value, right-aligned.
REQ-010 SHALL have port mask  input  MAX_W  per-bit compare enable (1 = compared).
REQ-011 SHALL have port SPItrig  output  1  one-cycle pulse on matching frame.
REQ-012 SHALL have port rx_data  output  MAX_W  last completed frame, right-aligned.
REQ-013 SHALL have port frm_err  output  1  one-cycle pulse on frame with bit count != len.

Function
REQ-014 SS_n, SCLK, MOSI SHALL pass through 2-flop synchronisers; a third flop SHALL be used for edge detection.
REQ-015 FSM SHALL have states IDLE and SHIFT.
REQ-016 IDLE->SHIFT on synchronised SS_n fall with en=1; bit counter and shift register SHALL clear on that cycle.
REQ-017 In SHIFT, each selected synchronised SCLK edge SHALL shift MOSI into the LSB (MSB-first protocol) and increment the counter, saturating at MAX_W+1.
REQ-018 SHIFT->IDLE on synchronised SS_n rise; same cycle SHALL load rx_data with the shift register.
REQ-019 At frame end with count == len, SPItrig SHALL pulse for exactly one clk if ((shift ^ match) & mask & lenmask) == 0, where lenmask is the low len bits set.
REQ-020 At frame end with count != len, frm_err SHALL pulse one clk and SPItrig SHALL stay 0.
REQ-021 len == 0 or len > MAX_W SHALL never produce SPItrig; frames SHALL still update rx_data and pulse frm_err.
REQ-022 SPItrig and frm_err SHALL be registered, high in the cycle after the 3rd clk edge following the SS_n pin rise.
REQ-023 SCLK edge coincident with detected SS_n rise SHALL be ignored; the rise takes priority.
REQ-024 SCLK edges while SS_n high or in IDLE SHALL be ignored.
REQ-025 en deasserting mid-frame SHALL return to IDLE without a pulse and leave rx_data unchanged; re-arm SHALL require a fresh SS_n fall.
REQ-026 Frames longer than MAX_W SHALL retain the last MAX_W bits and report frm_err.

Reset
REQ-027 rst_n low SHALL asynchronously force IDLE, counter 0, shift register 0, rx_data 0, SPItrig 0, frm_err 0, synchroniser flops to idle levels (SS_n=1, SCLK=0, MOSI=0).
REQ-028 Reset mid-frame SHALL discard the partial frame; the next trigger SHALL need a complete SS_n low period after release.

Configuration
REQ-029 With macro SPI_TRIG_MASK_EN defined, mask SHALL be applied as in REQ-019.
REQ-030 Without SPI_TRIG_MASK_EN, the mask port SHALL remain but be ignored (treated as all ones); no mask logic SHALL be synthesised.

Verification
REQ-031 16-bit frame 16'hBEEF, pos_edge=1, len=16, match=16'hBEEF, mask=16'hFFFF -> one SPItrig pulse, rx_data=16'hBEEF, frm_err=0.
REQ-032 8-bit frame 8'hBE, pos_edge=0, len=8, match=16'h00BE -> one SPItrig pulse, rx_data=16'h00BE.
REQ-033 Frame 16'hBEEE, len=16, match=16'hBEEF, mask=16'hFFFF -> no SPItrig, no frm_err, rx_data=16'hBEEE.
REQ-034 12-bit frame with len=16 -> frm_err one pulse, SPItrig 0; 20-bit frame with MAX_W=16 -> frm_err, rx_data = last 16 bits.
REQ-035 With SPI_TRIG_MASK_EN, frame 16'hBE12, match=16'hBE00, mask=16'hFF00 -> SPItrig pulse; without the macro -> no pulse.
REQ-036 rst_n low after 6 bits of 16'hBEEF, then a full 16'hBEEF frame -> exactly one SPItrig, on the second frame only.
